// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the core's single memory bus port between the instruction-fetch path
// (read-only) and the load/store unit (read/write). One transaction is
// outstanding at a time. The grant is latched in IDLE and held until the
// response handshake completes.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate, starting from the requester
//               that did not win last time (last_grant_reg tracks the winner).
//   undefined : fixed priority, the LSU wins simultaneous requests.
//
// Ports
//   clock, reset                     clock and synchronous active-high reset
//   if_req_*  / if_resp_*            fetch request / response handshakes
//   ls_req_*  / ls_resp_*            LSU request / response handshakes
//   mem_req_* / mem_resp_*           downstream bus bridge handshakes
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,

   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_resp_valid,
   input  logic                if_resp_ready,
   output logic [DATA_W-1:0]   if_resp_rdata,
   output logic                if_resp_err,

   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic                ls_req_wen,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_wstrb,
   output logic                ls_resp_valid,
   input  logic                ls_resp_ready,
   output logic [DATA_W-1:0]   ls_resp_rdata,
   output logic                ls_resp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_resp_rdata,
   input  logic                mem_resp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // grant encoding: 0 = IFU, 1 = LSU
   state_t state_reg, state_next;
   logic   grant_reg, grant_next;
`ifdef ARB_ROUND_ROBIN_EN
   logic   last_grant_reg, last_grant_next;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_reg <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_reg <= last_grant_next;
`endif
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_next = last_grant_reg;
`endif
      if_req_ready    = 1'b0;
      if_resp_valid   = 1'b0;
      if_resp_rdata   = '0;
      if_resp_err     = 1'b0;
      ls_req_ready    = 1'b0;
      ls_resp_valid   = 1'b0;
      ls_resp_rdata   = '0;
      ls_resp_err     = 1'b0;
      mem_req_valid   = 1'b0;
      mem_req_addr    = '0;
      mem_req_wen     = 1'b0;
      mem_req_wdata   = '0;
      mem_req_wstrb   = '0;
      mem_resp_ready  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (if_req_valid || ls_req_valid) begin
               state_next = REQ;
               if (if_req_valid && ls_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                  grant_next = ~last_grant_reg;
`else
                  grant_next = 1'b1;
`endif
               end else begin
                  // single requester: granted directly
                  grant_next = ls_req_valid;
               end
            end
         end

         REQ: begin
            mem_req_valid = 1'b1;
            if (grant_reg) begin
               mem_req_addr  = ls_req_addr;
               mem_req_wen   = ls_req_wen;
               mem_req_wdata = ls_req_wdata;
               mem_req_wstrb = ls_req_wstrb;
               ls_req_ready  = mem_req_ready;
            end else begin
               // fetch is read-only: write fields stay zero
               mem_req_addr  = if_req_addr;
               if_req_ready  = mem_req_ready;
            end
            if (mem_req_ready) begin
               state_next = RESP;
            end
         end

         RESP: begin
            if (grant_reg) begin
               ls_resp_valid  = mem_resp_valid;
               ls_resp_rdata  = mem_resp_rdata;
               ls_resp_err    = mem_resp_err;
               mem_resp_ready = ls_resp_ready;
            end else begin
               if_resp_valid  = mem_resp_valid;
               if_resp_rdata  = mem_resp_rdata;
               if_resp_err    = mem_resp_err;
               mem_resp_ready = if_resp_ready;
            end
            if (mem_resp_valid && mem_resp_ready) begin
               state_next = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_next = grant_reg;
`endif
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed testbench for mem_arbiter. Each scenario task drives stimulus and
// compares DUT outputs against hand-computed values. Inputs change #1 after
// the rising edge; outputs are sampled after a further #1 settle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                clock;
   logic                reset;
   logic                if_req_valid, if_req_ready;
   logic [ADDR_W-1:0]   if_req_addr;
   logic                if_resp_valid, if_resp_ready;
   logic [DATA_W-1:0]   if_resp_rdata;
   logic                if_resp_err;
   logic                ls_req_valid, ls_req_ready;
   logic [ADDR_W-1:0]   ls_req_addr;
   logic                ls_req_wen;
   logic [DATA_W-1:0]   ls_req_wdata;
   logic [DATA_W/8-1:0] ls_req_wstrb;
   logic                ls_resp_valid, ls_resp_ready;
   logic [DATA_W-1:0]   ls_resp_rdata;
   logic                ls_resp_err;
   logic                mem_req_valid, mem_req_ready;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_req_wen;
   logic [DATA_W-1:0]   mem_req_wdata;
   logic [DATA_W/8-1:0] mem_req_wstrb;
   logic                mem_resp_valid, mem_resp_ready;
   logic [DATA_W-1:0]   mem_resp_rdata;
   logic                mem_resp_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_req_addr    (if_req_addr),
      .if_resp_valid  (if_resp_valid),
      .if_resp_ready  (if_resp_ready),
      .if_resp_rdata  (if_resp_rdata),
      .if_resp_err    (if_resp_err),
      .ls_req_valid   (ls_req_valid),
      .ls_req_ready   (ls_req_ready),
      .ls_req_addr    (ls_req_addr),
      .ls_req_wen     (ls_req_wen),
      .ls_req_wdata   (ls_req_wdata),
      .ls_req_wstrb   (ls_req_wstrb),
      .ls_resp_valid  (ls_resp_valid),
      .ls_resp_ready  (ls_resp_ready),
      .ls_resp_rdata  (ls_resp_rdata),
      .ls_resp_err    (ls_resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wstrb  (mem_req_wstrb),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_rdata (mem_resp_rdata),
      .mem_resp_err   (mem_resp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      if_req_valid = 0; if_req_addr = '0; if_resp_ready = 0;
      ls_req_valid = 0; ls_req_addr = '0; ls_req_wen = 0;
      ls_req_wdata = '0; ls_req_wstrb = '0; ls_resp_ready = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      if_req_valid = 1; ls_req_valid = 1; mem_resp_valid = 1; mem_req_ready = 1;
      if_resp_ready = 1; ls_resp_ready = 1;
      tick(); tick();
      n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got=%0h exp=0", mem_req_valid); end
      n_checks++; if ({if_req_ready, ls_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", {if_req_ready, ls_req_ready}); end
      n_checks++; if ({if_resp_valid, ls_resp_valid, mem_resp_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_resp got=%b exp=000", {if_resp_valid, ls_resp_valid, mem_resp_ready}); end
      n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_req_addr got=%h exp=00000000", mem_req_addr); end
      reset = 0;
      clear_inputs();
      $display("txn reset: outputs idle");
   endtask

   task automatic test_ifu_only();
      int ls_seen;
      ls_seen = 0;
      apply_reset();
      if_req_valid = 1; if_req_addr = 32'h3000_0000; if_resp_ready = 1;
      settle();
      // cycle N: still IDLE
      n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_n_mem_req_valid got=%0h exp=0", mem_req_valid); end
      tick();
      // cycle N+1: REQ
      mem_req_ready = 1;
      settle();
      n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_n1_mem_req_valid got=%0h exp=1", mem_req_valid); end
      n_checks++; if (mem_req_addr !== 32'h3000_0000) begin n_fail++; $display("FAIL ifu_addr got=%h exp=30000000", mem_req_addr); end
      n_checks++; if ({mem_req_wen, mem_req_wdata, mem_req_wstrb} !== 37'h0) begin n_fail++; $display("FAIL ifu_write_fields got=%h exp=0", {mem_req_wen, mem_req_wdata, mem_req_wstrb}); end
      n_checks++; if ({if_req_ready, ls_req_ready} !== 2'b10) begin n_fail++; $display("FAIL ifu_req_ready got=%b exp=10", {if_req_ready, ls_req_ready}); end
      if (ls_resp_valid) ls_seen++;
      tick();
      // cycle N+2: RESP
      if_req_valid = 0; mem_req_ready = 0;
      mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
      settle();
      n_checks++; if (if_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_resp_valid got=%0h exp=1", if_resp_valid); end
      n_checks++; if (if_resp_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL ifu_resp_rdata got=%h exp=00000413", if_resp_rdata); end
      n_checks++; if (mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL ifu_mem_resp_ready got=%0h exp=1", mem_resp_ready); end
      n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_resp_mem_req_valid got=%0h exp=0", mem_req_valid); end
      if (ls_resp_valid) ls_seen++;
      tick();
      mem_resp_valid = 0;
      settle();
      if (ls_resp_valid) ls_seen++;
      n_checks++; if (ls_seen !== 0) begin n_fail++; $display("FAIL ifu_ls_resp_seen got=%0d exp=0", ls_seen); end
      n_checks++; if ({mem_req_valid, if_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL ifu_back_idle got=%b exp=00", {mem_req_valid, if_resp_valid}); end
      $display("txn ifu read addr=30000000 rdata=%h", if_resp_rdata);
      clear_inputs();
   endtask

   task automatic test_lsu_store();
      int pulses;
      int if_ready_seen;
      pulses = 0; if_ready_seen = 0;
      apply_reset();
      ls_req_valid = 1; ls_req_addr = 32'h8000_0010; ls_req_wen = 1;
      ls_req_wdata = 32'hDEAD_BEEF; ls_req_wstrb = 4'hF; ls_resp_ready = 1;
      if_resp_ready = 1;
      settle();
      if (if_req_ready) if_ready_seen++;
      tick();
      mem_req_ready = 1;
      settle();
      n_checks++; if (mem_req_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL st_addr got=%h exp=80000010", mem_req_addr); end
      n_checks++; if (mem_req_wen !== 1'b1) begin n_fail++; $display("FAIL st_wen got=%0h exp=1", mem_req_wen); end
      n_checks++; if (mem_req_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_wdata got=%h exp=deadbeef", mem_req_wdata); end
      n_checks++; if (mem_req_wstrb !== 4'hF) begin n_fail++; $display("FAIL st_wstrb got=%h exp=f", mem_req_wstrb); end
      n_checks++; if (ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL st_ls_req_ready got=%0h exp=1", ls_req_ready); end
      if (if_req_ready) if_ready_seen++;
      tick();
      ls_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1;
      for (int i = 0; i < 4; i++) begin
         settle();
         if (ls_resp_valid) pulses++;
         if (if_req_ready) if_ready_seen++;
         tick();
         mem_resp_valid = 0;
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL st_resp_pulses got=%0d exp=1", pulses); end
      n_checks++; if (if_ready_seen !== 0) begin n_fail++; $display("FAIL st_if_req_ready got=%0d exp=0", if_ready_seen); end
      $display("txn lsu store addr=80000010 wdata=deadbeef wstrb=f");
      clear_inputs();
   endtask

   task automatic test_simultaneous();
      logic [2:0] exp_seq;
      logic       exp_ls;
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = 3'b101;   // round 0 -> LSU, 1 -> IFU, 2 -> LSU
`else
      exp_seq = 3'b111;
`endif
      apply_reset();
      if_resp_ready = 1; ls_resp_ready = 1;
      for (int r = 0; r < 3; r++) begin
         exp_ls = exp_seq[r];
         if_req_valid = 1; if_req_addr = 32'h0000_1000 + 32'(r);
         ls_req_valid = 1; ls_req_addr = 32'h8000_2000 + 32'(r);
         tick();
         mem_req_ready = 1;
         settle();
         n_checks++; if (mem_req_addr !== (exp_ls ? 32'h8000_2000 + 32'(r) : 32'h0000_1000 + 32'(r))) begin n_fail++; $display("FAIL sim_addr_r%0d got=%h exp_lsu=%0d", r, mem_req_addr, exp_ls); end
         n_checks++; if ({ls_req_ready, if_req_ready} !== {exp_ls, ~exp_ls}) begin n_fail++; $display("FAIL sim_ready_r%0d got=%b exp=%b", r, {ls_req_ready, if_req_ready}, {exp_ls, ~exp_ls}); end
         tick();
         mem_req_ready = 0;
         if (exp_ls) ls_req_valid = 0; else if_req_valid = 0;
         mem_resp_valid = 1; mem_resp_rdata = 32'h1234_0000 + 32'(r);
         settle();
         n_checks++; if ({ls_resp_valid, if_resp_valid} !== {exp_ls, ~exp_ls}) begin n_fail++; $display("FAIL sim_resp_r%0d got=%b exp=%b", r, {ls_resp_valid, if_resp_valid}, {exp_ls, ~exp_ls}); end
         tick();
         mem_resp_valid = 0;
         $display("txn simultaneous round=%0d granted=%s", r, exp_ls ? "LSU" : "IFU");
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      int done;
      done = 0;
      apply_reset();
      if_req_valid = 1; if_req_addr = 32'h3000_0040;
      tick();
      for (int i = 0; i < 4; i++) begin
         settle();
         n_checks++; if ({mem_req_valid, if_req_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_req_hold_c%0d got=%b exp=10", i, {mem_req_valid, if_req_ready}); end
         tick();
      end
      mem_req_ready = 1;
      settle();
      n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept got=%0h exp=1", if_req_ready); end
      tick();
      if_req_valid = 0; mem_req_ready = 0;
      mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_0001; if_resp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_checks++; if ({mem_req_valid, if_resp_valid, mem_resp_ready} !== 3'b010) begin n_fail++; $display("FAIL bp_resp_hold_c%0d got=%b exp=010", i, {mem_req_valid, if_resp_valid, mem_resp_ready}); end
         tick();
      end
      if_resp_ready = 1;
      settle();
      n_checks++; if (mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resp_release got=%0h exp=1", mem_resp_ready); end
      if (if_resp_valid && if_resp_ready) done++;
      tick();
      // mem_resp_valid left high: back in IDLE it must not be forwarded
      settle();
      if (if_resp_valid && if_resp_ready) done++;
      tick();
      settle();
      if (if_resp_valid && if_resp_ready) done++;
      n_checks++; if (done !== 1) begin n_fail++; $display("FAIL bp_completions got=%0d exp=1", done); end
      n_checks++; if ({mem_req_valid, mem_resp_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_idle got=%b exp=00", {mem_req_valid, mem_resp_ready}); end
      $display("txn backpressure ifu read addr=30000040 completions=%0d", done);
      clear_inputs();
   endtask

   task automatic test_error();
      apply_reset();
      ls_req_valid = 1; ls_req_addr = 32'h8000_0100; ls_req_wen = 0; ls_resp_ready = 1;
      tick();
      mem_req_ready = 1;
      settle();
      n_checks++; if ({mem_req_valid, mem_req_wen, ls_req_ready} !== 3'b101) begin n_fail++; $display("FAIL err_req got=%b exp=101", {mem_req_valid, mem_req_wen, ls_req_ready}); end
      tick();
      ls_req_valid = 0; mem_req_ready = 0;
      mem_resp_valid = 1; mem_resp_err = 1; mem_resp_rdata = 32'hBAD0_0BAD;
      settle();
      n_checks++; if ({ls_resp_valid, ls_resp_err, if_resp_err} !== 3'b110) begin n_fail++; $display("FAIL err_resp got=%b exp=110", {ls_resp_valid, ls_resp_err, if_resp_err}); end
      tick();
      mem_resp_valid = 0; mem_resp_err = 0;
      $display("txn lsu load addr=80000100 err=1");
      if_req_valid = 1; if_req_addr = 32'h3000_0080; if_resp_ready = 1;
      settle();
      n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_idle got=%0h exp=0", mem_req_valid); end
      tick();
      mem_req_ready = 1;
      settle();
      n_checks++; if ({mem_req_valid, if_req_ready} !== 2'b11 || mem_req_addr !== 32'h3000_0080) begin n_fail++; $display("FAIL err_next_req got=%b addr=%h exp=11 30000080", {mem_req_valid, if_req_ready}, mem_req_addr); end
      tick();
      if_req_valid = 0; mem_req_ready = 0;
      mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0093;
      settle();
      n_checks++; if ({if_resp_valid, if_resp_err} !== 2'b10 || if_resp_rdata !== 32'h0000_0093) begin n_fail++; $display("FAIL err_next_resp got=%b rdata=%h exp=10 00000093", {if_resp_valid, if_resp_err}, if_resp_rdata); end
      tick();
      $display("txn ifu read addr=30000080 rdata=00000093 after error");
      clear_inputs();
   endtask

   task automatic test_reset_in_resp();
      apply_reset();
      ls_req_valid = 1; ls_req_addr = 32'h8000_0200; ls_resp_ready = 0;
      tick();
      mem_req_ready = 1;
      tick();
      ls_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1;
      settle();
      n_checks++; if (ls_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_in_resp got=%0h exp=1", ls_resp_valid); end
      reset = 1;
      tick();
      reset = 0;
      settle();
      n_checks++; if ({if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, mem_resp_ready} !== 6'b0) begin n_fail++; $display("FAIL rr_idle got=%b exp=000000", {if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, mem_resp_ready}); end
      // stray response keeps arriving; it must stay blocked
      ls_resp_ready = 1; if_resp_ready = 1;
      tick();
      settle();
      n_checks++; if ({ls_resp_valid, if_resp_valid, mem_resp_ready} !== 3'b000) begin n_fail++; $display("FAIL rr_stray got=%b exp=000", {ls_resp_valid, if_resp_valid, mem_resp_ready}); end
      $display("txn reset during response abandoned addr=80000200");
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_ifu_only();
      test_lsu_store();
      test_simultaneous();
      test_backpressure();
      test_error();
      test_reset_in_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one arbiter that shares the core's single memory bus port between the instruction-fetch path (read-only) and the load/store unit (read/write). It sits between the fetch/LSU request interfaces and the downstream bus bridge. It serializes transactions and locks the grant from request acceptance until the response handshake completes. Only one transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_req_valid / if_req_ready  in / out  1  fetch request handshake
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid / if_resp_ready  out / in  1  fetch response handshake
- if_resp_rdata  out  DATA_W  fetched word
- if_resp_err  out  1  bus error on fetch
- ls_req_valid / ls_req_ready  in / out  1  LSU request handshake
- ls_req_addr  in  ADDR_W  LSU address
- ls_req_wen  in  1  1 = store, 0 = load
- ls_req_wdata  in  DATA_W  store data
- ls_req_wstrb  in  DATA_W/8  byte strobes
- ls_resp_valid / ls_resp_ready  out / in  1  LSU response handshake
- ls_resp_rdata  out  DATA_W  load data
- ls_resp_err  out  1  bus error on LSU access
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb  out  as LSU  downstream request
- mem_resp_valid / mem_resp_ready  in / out  1  downstream response handshake
- mem_resp_rdata  in  DATA_W  downstream read data
- mem_resp_err  in  1  downstream error

## Operation
- State machine with three states: IDLE, REQ, RESP. Registered `grant` (0 = IFU, 1 = LSU).
- IDLE:
  - If any request valid is high, register `grant` and go to REQ.
  - If none is valid, stay in IDLE.
  - All ready/valid outputs are 0 in IDLE.
- REQ:
  - mem_req_valid=1. mem_req_* carry the granted requester's fields.
  - For an IFU grant: mem_req_wen=0, wdata=0, wstrb=0.
  - The granted requester's req_ready is wired to mem_req_ready. The other requester's req_ready=0.
  - On the mem_req handshake, go to RESP.
- RESP:
  - mem_resp_valid, rdata and err are routed to the granted requester only.
  - mem_resp_ready is wired to the granted requester's resp_ready.
  - On the response handshake, go to IDLE.
- Requesters hold valid and payload stable until req_ready. Dropping valid before acceptance is a protocol violation and is not handled.
- An ungranted requester's valid stays pending and is re-arbitrated in the next IDLE.
- Responses with mem_resp_err=1 pass through unchanged. No retry.
- mem_resp_valid outside RESP is ignored and never forwarded.

## Timing
- Reset puts the state machine in IDLE and sets grant=0 and last_grant=0 (IFU). This makes every ready/valid output 0. Data outputs are don't-care, driven 0.
- Arbitration adds one cycle: a valid seen in IDLE at cycle N gives mem_req_valid at N+1.
- Earliest request-to-response: accept at N+1 with mem_req_ready=1, forward the response at N+2 if mem_resp_valid=1, return to IDLE at N+3.
- Back-to-back throughput is one transaction per 3 cycles minimum.
- Resp outputs are combinational from mem_resp_* in RESP. There is no extra latency.
- A reset mid-transaction returns the block to IDLE in the next cycle and abandons any outstanding transaction. The downstream bridge shares this reset.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests in IDLE, grant the requester that did not win last time (last_grant inverted).
  - last_grant updates on each response handshake.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, LSU wins all simultaneous requests.
  - The last_grant register is omitted.
- A single requester is granted immediately in both modes.

## Test plan
- IFU only: if_req addr 0x30000000, mem_req_ready=1, mem_resp rdata 0x00000413 one cycle later.
  - Expect mem_req_valid the cycle after if_req_valid, mem_req_wen=0, if_resp_rdata=0x00000413, ls_resp_valid never 1.
- LSU store: addr 0x80000010, wdata 0xDEADBEEF, wstrb 0xF.
  - Expect mem_req fields match exactly and ls_resp_valid pulses once.
  - Expect if_req_ready=0 throughout.
- Simultaneous IFU and LSU valid, three times in a row:
  - Without the macro, expect grants LSU, LSU, LSU.
  - With ARB_ROUND_ROBIN_EN, after reset expect grants LSU, IFU, LSU.
- Backpressure: mem_req_ready low for 4 cycles, then mem_resp_valid high while if_resp_ready low for 3 cycles.
  - Expect the FSM to hold in REQ, then in RESP.
  - Expect mem_resp_ready=0 until if_resp_ready=1, and exactly one completion.
- Error: mem_resp_err=1 on an LSU load.
  - Expect ls_resp_err=1, the FSM returns to IDLE, and the next IFU request proceeds normally.
- Reset asserted while in RESP.
  - Expect the next cycle IDLE with all valid/ready outputs 0.
  - A stray mem_resp_valid afterwards is not forwarded.
